// File: rtl/predictor_gshare_btb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | predictor_gshare_btb: tagged BTB + saturating counters, optional gshare  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module predictor_gshare_btb #(
   parameter int NUM_ENTRIES = 64,
   parameter int CNT_W       = 2,
   parameter int TAG_W       = 8,
   parameter int GHR_W       = 6,
   parameter int SHADOW      = 1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [31:0]                            if_predict_pc_i,
   output logic                                   if_predict_taken_o,
   output logic [31:0]                            if_predict_targetPc_o,
   output logic                                   if_predict_hit_o,
   output logic [((GHR_W > 0) ? GHR_W : 1)-1:0]   if_predict_ghr_o,
   input  logic                                   id_update_isJumpInst_i,
   input  logic [31:0]                            id_update_pc_i,
   input  logic [31:0]                            id_update_targetPc_i,
   input  logic                                   id_update_taken_i,
   input  logic                                   id_update_predTaken_i,
   input  logic [31:0]                            id_update_predTargetPc_i,
   input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0]   id_update_ghr_i,
   output logic                                   if_predict_failed_o,
   output logic [31:0]                            if_flush_pc_o,
   output logic [31:0]                            stat_branch_cnt_o,
   output logic [31:0]                            stat_miss_cnt_o
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

   logic [TAG_W-1:0]       r_tag    [NUM_ENTRIES];
   logic [31:0]            r_target [NUM_ENTRIES];
   logic [CNT_W-1:0]       r_cnt    [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] r_valid;
   logic [GW-1:0]          r_ghr;
   logic [1:0]             r_shadow;
   logic [31:0]            r_branch_cnt;
   logic [31:0]            r_miss_cnt;

   logic [IDX_W-1:0] w_bidx_if, w_pidx_if, w_bidx_up, w_pidx_up;
   logic [TAG_W-1:0] w_tag_if, w_tag_up;
   logic             w_hit, w_taken, w_acc, w_failed;

   // Fetch-side lookup: BTB by PC bits, direction counter by PC xor live history
   assign w_bidx_if = if_predict_pc_i[IDX_W+1:2];
   assign w_pidx_if = w_bidx_if ^ IDX_W'(r_ghr);
   assign w_tag_if  = if_predict_pc_i[IDX_W+1+TAG_W:IDX_W+2];
   assign w_hit     = r_valid[w_bidx_if] && (r_tag[w_bidx_if] == w_tag_if);
   assign w_taken   = w_hit && r_cnt[w_pidx_if][CNT_W-1];

   assign if_predict_hit_o      = w_hit;
   assign if_predict_taken_o    = w_taken;
   assign if_predict_targetPc_o = w_taken ? r_target[w_bidx_if] : (if_predict_pc_i + 32'd4);
   assign if_predict_ghr_o      = r_ghr;

   // Resolve side: the counter index uses the snapshot carried from fetch
   assign w_bidx_up = id_update_pc_i[IDX_W+1:2];
   assign w_pidx_up = w_bidx_up ^ IDX_W'(id_update_ghr_i);
   assign w_tag_up  = id_update_pc_i[IDX_W+1+TAG_W:IDX_W+2];
   assign w_acc     = id_update_isJumpInst_i && (r_shadow == 2'd0) && !rst_i;
   assign w_failed  = w_acc && ((id_update_taken_i != id_update_predTaken_i) ||
                      (id_update_taken_i && (id_update_targetPc_i != id_update_predTargetPc_i)));

   assign if_predict_failed_o = w_failed;
   assign if_flush_pc_o       = id_update_taken_i ? id_update_targetPc_i : (id_update_pc_i + 32'd4);
   assign stat_branch_cnt_o   = r_branch_cnt;
   assign stat_miss_cnt_o     = r_miss_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_cnt[i] <= CNT_INIT;
         end
      end else if (w_acc) begin
         if (id_update_taken_i) begin
            r_valid[w_bidx_up] <= 1'b1;
            if (r_cnt[w_pidx_up] != {CNT_W{1'b1}}) begin
               r_cnt[w_pidx_up] <= r_cnt[w_pidx_up] + 1'b1;
            end
         end else if (r_cnt[w_pidx_up] != '0) begin
            r_cnt[w_pidx_up] <= r_cnt[w_pidx_up] - 1'b1;
         end
      end
   end

   // Tags and targets are qualified by r_valid, so they carry no reset
   always_ff @(posedge clk_i) begin
      if (w_acc && id_update_taken_i) begin
         r_tag[w_bidx_up]    <= w_tag_up;
         r_target[w_bidx_up] <= id_update_targetPc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ghr        <= '0;
         r_shadow     <= 2'd0;
         r_branch_cnt <= '0;
         r_miss_cnt   <= '0;
      end else begin
         if (w_acc && (GHR_W > 0)) begin
            r_ghr <= GW'({r_ghr, id_update_taken_i});
         end
         if (w_failed) begin
            r_shadow <= 2'(SHADOW);
         end else if (r_shadow != 2'd0) begin
            r_shadow <= r_shadow - 2'd1;
         end
         if (w_acc && (r_branch_cnt != 32'hFFFF_FFFF)) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
         end
         if (w_failed && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_predictor_gshare_btb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_predictor_gshare_btb: directed bench, bimodal and gshare instances    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_predictor_gshare_btb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pred_pc;
   logic        upd_valid, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        upd_ghr_a;
   logic [5:0]  upd_ghr_g;

   logic        a_taken, a_hit, a_failed, a_ghr;
   logic [31:0] a_target, a_flush, a_branch, a_miss;
   logic        g_taken, g_hit, g_failed;
   logic [5:0]  g_ghr;
   logic [31:0] g_target, g_flush, g_branch, g_miss;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   predictor_gshare_btb #(.NUM_ENTRIES(64), .CNT_W(2), .TAG_W(8), .GHR_W(0), .SHADOW(1)) dut (
      .clk_i(clk), .rst_i(rst), .if_predict_pc_i(pred_pc),
      .if_predict_taken_o(a_taken), .if_predict_targetPc_o(a_target),
      .if_predict_hit_o(a_hit), .if_predict_ghr_o(a_ghr),
      .id_update_isJumpInst_i(upd_valid), .id_update_pc_i(upd_pc),
      .id_update_targetPc_i(upd_target), .id_update_taken_i(upd_taken),
      .id_update_predTaken_i(upd_pred_taken), .id_update_predTargetPc_i(upd_pred_target),
      .id_update_ghr_i(upd_ghr_a), .if_predict_failed_o(a_failed),
      .if_flush_pc_o(a_flush), .stat_branch_cnt_o(a_branch), .stat_miss_cnt_o(a_miss));

   predictor_gshare_btb #(.NUM_ENTRIES(64), .CNT_W(2), .TAG_W(8), .GHR_W(6), .SHADOW(1)) dut_g (
      .clk_i(clk), .rst_i(rst), .if_predict_pc_i(pred_pc),
      .if_predict_taken_o(g_taken), .if_predict_targetPc_o(g_target),
      .if_predict_hit_o(g_hit), .if_predict_ghr_o(g_ghr),
      .id_update_isJumpInst_i(upd_valid), .id_update_pc_i(upd_pc),
      .id_update_targetPc_i(upd_target), .id_update_taken_i(upd_taken),
      .id_update_predTaken_i(upd_pred_taken), .id_update_predTargetPc_i(upd_pred_target),
      .id_update_ghr_i(upd_ghr_g), .if_predict_failed_o(g_failed),
      .if_flush_pc_o(g_flush), .stat_branch_cnt_o(g_branch), .stat_miss_cnt_o(g_miss));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic ptk, input logic [31:0] ptgt);
      upd_valid       = v;
      upd_pc          = pc;
      upd_target      = tgt;
      upd_taken       = tk;
      upd_pred_taken  = ptk;
      upd_pred_target = ptgt;
   endtask

   initial begin
      rst       = 1'b1;
      pred_pc   = 32'h8000_0010;
      upd_ghr_a = 1'b0;
      upd_ghr_g = 6'd0;
      // An update presented during reset must be discarded
      set_upd(1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0, 32'h8000_0014);
      tick();
      check("rst_failed", {31'd0, a_failed}, 32'd0);
      tick();
      rst = 1'b0;
      set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check("rst_hit", {31'd0, a_hit}, 32'd0);
      check("rst_taken", {31'd0, a_taken}, 32'd0);
      check("rst_target", a_target, 32'h8000_0014);
      check("rst_branch", a_branch, 32'd0);
      check("rst_miss", a_miss, 32'd0);
      check("rst_ghr_g", {26'd0, g_ghr}, 32'd0);

      // First taken update: mispredict, prediction still sees old contents
      set_upd(1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0, 32'h8000_0014);
      #1;
      check("mp1_failed", {31'd0, a_failed}, 32'd1);
      check("mp1_flush", a_flush, 32'h8000_0100);
      check("mp1_rbw_hit", {31'd0, a_hit}, 32'd0);
      tick();
      // Shadow cycle: update ignored
      #1;
      check("shadow_failed", {31'd0, a_failed}, 32'd0);
      check("trained_hit", {31'd0, a_hit}, 32'd1);
      check("trained_taken", {31'd0, a_taken}, 32'd1);
      check("trained_target", a_target, 32'h8000_0100);
      check("mp1_miss", a_miss, 32'd1);
      check("mp1_branch", a_branch, 32'd1);
      tick();
      set_upd(1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0100);
      #1;
      check("shadow_branch_hold", a_branch, 32'd1);
      check("ok_failed", {31'd0, a_failed}, 32'd0);
      tick();
      // Counter is now 11: a not-taken resolution leaves it at 10 (still taken)
      set_upd(1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0, 1'b1, 32'h8000_0100);
      #1;
      check("acc2_branch", a_branch, 32'd2);
      check("nt_failed", {31'd0, a_failed}, 32'd1);
      check("nt_flush", a_flush, 32'h8000_0014);
      tick();
      set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check("sat_cnt_taken", {31'd0, a_taken}, 32'd1);
      check("nt_miss", a_miss, 32'd2);
      check("nt_branch", a_branch, 32'd3);
      tick();

      // Taken with wrong target
      set_upd(1'b1, 32'h8000_0010, 32'h8000_0200, 1'b1, 1'b1, 32'h8000_0100);
      #1;
      check("wt_failed", {31'd0, a_failed}, 32'd1);
      check("wt_flush", a_flush, 32'h8000_0200);
      tick();
      set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check("wt_target", a_target, 32'h8000_0200);
      check("wt_taken", {31'd0, a_taken}, 32'd1);
      check("wt_miss", a_miss, 32'd3);
      check("wt_branch", a_branch, 32'd4);
      tick();

      // Same bidx, different tag
      pred_pc = 32'h8000_1010;
      #1;
      check("alias_hit", {31'd0, a_hit}, 32'd0);
      check("alias_taken", {31'd0, a_taken}, 32'd0);
      check("alias_target", a_target, 32'h8000_1014);
      pred_pc = 32'h8000_0010;

      // Stats saturation
      force dut.r_branch_cnt = 32'hFFFF_FFFF;
      force dut.r_miss_cnt   = 32'hFFFF_FFFF;
      #1;
      release dut.r_branch_cnt;
      release dut.r_miss_cnt;
      set_upd(1'b1, 32'h8000_0010, 32'h8000_0300, 1'b1, 1'b0, 32'h8000_0014);
      #1;
      check("sat_failed", {31'd0, a_failed}, 32'd1);
      tick();
      set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check("sat_branch", a_branch, 32'hFFFF_FFFF);
      check("sat_miss", a_miss, 32'hFFFF_FFFF);

      // Gshare phase (mid-operation reset)
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("g_rst_ghr", {26'd0, g_ghr}, 32'd0);
      check("a_rst_branch", a_branch, 32'd0);
      // bidx 5 trained with snapshot 63 -> pidx 58, leaving counter 5 weak NT
      set_upd(1'b1, 32'h8000_0014, 32'h8000_0300, 1'b1, 1'b1, 32'h8000_0300);
      upd_ghr_g = 6'h3F;
      #1;
      check("g_u1_failed", {31'd0, g_failed}, 32'd0);
      tick();
      set_upd(1'b1, 32'h8000_0004, 32'h8000_0400, 1'b1, 1'b1, 32'h8000_0400);
      upd_ghr_g = 6'd1;
      #1;
      check("g_u1_ghr", {26'd0, g_ghr}, 32'd1);
      tick();
      upd_ghr_g = 6'd3;
      tick();
      set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      upd_ghr_g = 6'd0;
      pred_pc   = 32'h8000_0014;
      #1;
      check("g_ghr", {26'd0, g_ghr}, 32'h7);
      check("g_hit", {31'd0, g_hit}, 32'd1);
      check("g_taken_pidx2", {31'd0, g_taken}, 32'd1);
      check("g_target", g_target, 32'h8000_0300);
      check("g_branch", g_branch, 32'd3);
      check("a_ghr_tied", {31'd0, a_ghr}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
